// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// access-size codes from sign_mask[2:0] and the sign-select bit position.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_BUF,
        ST_FINISH,
        ST_WRITE
    } state_t;

    localparam logic [2:0] SZ_BYTE  = 3'b001;
    localparam logic [2:0] SZ_HALF  = 3'b011;
    localparam logic [2:0] SZ_WORD  = 3'b111;
    localparam int         SIGN_BIT = 3;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_t;

    // Any size code other than byte or half behaves as a full word.
    function automatic acc_size_t decode_size(input logic [2:0] i_size);
        case (i_size)
            SZ_BYTE: return ACC_BYTE;
            SZ_HALF: return ACC_HALF;
            default: return ACC_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends a load result from the
// buffered word, and merges store data into it for read-modify-write.
module dmem_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [31:0] i_buf_word,
    input  logic [31:0] i_write_data,
    input  logic [1:0]  i_byte_off,
    input  logic [3:0]  i_sign_mask,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged,
    output logic        o_misaligned
);

    acc_size_t   w_size;
    logic        w_signed;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        w_size       = decode_size(i_sign_mask[2:0]);
        w_signed     = i_sign_mask[SIGN_BIT];
        w_shift      = {i_byte_off, 3'b000};
        w_byte       = 8'(i_buf_word >> w_shift);
        w_half       = i_byte_off[1] ? i_buf_word[31:16] : i_buf_word[15:0];
        o_load_data  = i_buf_word;
        o_merged     = i_write_data;
        o_misaligned = 1'b0;

        case (w_size)
            ACC_BYTE: begin
                o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
                o_merged    = (i_buf_word & ~(32'h0000_00FF << w_shift))
                            | ({24'h0, i_write_data[7:0]} << w_shift);
            end
            ACC_HALF: begin
                // addr[0] is ignored: an odd half is performed on its aligned lane.
                o_load_data  = {{16{w_signed & w_half[15]}}, w_half};
                o_merged     = i_byte_off[1] ? {i_write_data[15:0], i_buf_word[15:0]}
                                             : {i_buf_word[31:16], i_write_data[15:0]};
                o_misaligned = i_byte_off[0];
            end
            default: begin
                o_misaligned = (i_sign_mask[2:0] == SZ_WORD) && (i_byte_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised BRAM behind a 3-edge access FSM,
// with sub-word loads and read-modify-write stores; clk_stall covers each access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic        misaligned
);

    state_t                 r_state;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [1:0]             r_off;
    logic [31:0]            r_wdata;
    logic [3:0]             r_mask;
    logic                   r_is_store;
    logic [31:0]            r_buf;
    logic [31:0]            r_mem [DEPTH];

    logic [31:0]            w_load_data;
    logic [31:0]            w_merged;
    logic                   w_misaligned;
    logic                   w_unused_addr_bits;

    // Upper address bits fold away: the word index wraps modulo DEPTH.
    assign w_unused_addr_bits = &{1'b0, addr[31:ADDR_BITS+2]};

    dmem_lane_unit u_lane (
        .i_buf_word   (r_buf),
        .i_write_data (r_wdata),
        .i_byte_off   (r_off),
        .i_sign_mask  (r_mask),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            r_state    <= ST_IDLE;
            read_data  <= 32'h0;
            clk_stall  <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (memread || memwrite) begin
                        r_idx      <= addr[ADDR_BITS+1:2];
                        r_off      <= addr[1:0];
                        r_wdata    <= write_data;
                        r_mask     <= sign_mask;
                        r_is_store <= memwrite;
                        r_state    <= ST_READ_BUF;
                        clk_stall  <= 1'b1;
                    end
                end
                ST_READ_BUF: begin
                    r_state <= r_is_store ? ST_WRITE : ST_FINISH;
                end
                ST_FINISH: begin
                    read_data  <= w_load_data;
                    misaligned <= w_misaligned;
                    r_state    <= ST_IDLE;
                    clk_stall  <= 1'b0;
                end
                ST_WRITE: begin
                    misaligned <= w_misaligned;
                    r_state    <= ST_IDLE;
                    clk_stall  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    clk_stall <= 1'b0;
                end
            endcase
        end
    end

    // Single-port BRAM with synchronous read; a reset at the WRITE edge blocks the commit.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset so it maps onto block RAM.
        if (r_state == ST_READ_BUF) begin
            r_buf <= r_mem[r_idx];
        end
        if (!reset && r_state == ST_WRITE) begin
            r_mem[r_idx] <= w_merged;
        end
    end

endmodule
